// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and the oversample default shared by
// baud_gen, uart_tx and uart_rx.
package uart_pkg;

    localparam int UART_OSR = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchroniser for an asynchronous input, resetting to 1
// so an idle-high line reads idle straight out of reset.
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_r;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_r <= {N{1'b1}};
        end else begin
            sync_r <= {sync_r[N-2:0], d_i};
        end
    end

    assign q_o = sync_r[N-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with midpoint sampling and a one-entry holding
// register. Defining UART_RX_PARITY_EN adds a parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OSR         = UART_OSR,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              osr_tick_i,
    input  logic              rx_i,
`ifdef UART_RX_PARITY_EN
    input  logic              parity_odd_i,
    output logic              parity_err_o,
`endif
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o
);

    localparam int OS_W = $clog2(OSR);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [OS_W-1:0] OS_ZERO = OS_W'(0);
    localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
    localparam logic [BC_W-1:0] BC_ZERO = BC_W'(0);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    rx_state_t         state_r, state_s;
    logic [OS_W-1:0]   os_cnt_r, os_cnt_s;
    logic [BC_W-1:0]   bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic              valid_r, valid_s;
    logic              frame_err_r, frame_err_s;
    logic              overrun_r, overrun_s;
    logic              frame_good_s;
    logic              rx_s;

`ifdef UART_RX_PARITY_EN
    logic par_bit_r, par_bit_s;
    logic parity_err_r, parity_err_s;

    function automatic logic calc_parity_err(input logic [DATA_W-1:0] d,
                                             input logic p, input logic odd);
        return ((^d) ^ p) != odd;
    endfunction
`endif

    uart_sync #(.N(SYNC_STAGES)) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (rx_i),
        .q_o     (rx_s)
    );

    // Frame FSM next-state: moves only on enabled ticks, clears when disabled.
    always_comb begin
        state_s      = state_r;
        os_cnt_s     = os_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        frame_good_s = 1'b0;
        frame_err_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_s    = par_bit_r;
        parity_err_s = 1'b0;
`endif
        if (!en_i) begin
            state_s   = IDLE;
            os_cnt_s  = OS_ZERO;
            bit_cnt_s = BC_ZERO;
        end else if (osr_tick_i) begin
            case (state_r)
                IDLE: begin
                    if (rx_s == 1'b0) begin
                        state_s  = START;
                        os_cnt_s = OS_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    if (os_cnt_r == OS_MID) begin
                        state_s   = rx_s ? IDLE : DATA;
                        os_cnt_s  = OS_ZERO;
                        bit_cnt_s = BC_ZERO;
                    end else begin
                        os_cnt_s = os_cnt_r + OS_ONE;
                    end
                end
                DATA: begin
                    if (os_cnt_r == OS_LAST) begin
                        shift_s   = {rx_s, shift_r[DATA_W-1:1]};
                        os_cnt_s  = OS_ZERO;
                        bit_cnt_s = bit_cnt_r + BC_ONE;
                        if (bit_cnt_r == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_s = PARITY;
`else
                            state_s = STOP;
`endif
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        os_cnt_s = os_cnt_r + OS_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_cnt_r == OS_LAST) begin
                        par_bit_s = rx_s;
                        os_cnt_s  = OS_ZERO;
                        state_s   = STOP;
                    end else begin
                        os_cnt_s = os_cnt_r + OS_ONE;
                    end
                end
`endif
                STOP: begin
                    // Sampled mid stop bit so a following start edge is not missed.
                    if (os_cnt_r == OS_LAST) begin
                        state_s     = IDLE;
                        os_cnt_s    = OS_ZERO;
                        bit_cnt_s   = BC_ZERO;
                        frame_err_s = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_s = calc_parity_err(shift_r, par_bit_r, parity_odd_i);
                        frame_good_s = rx_s & ~parity_err_s;
`else
                        frame_good_s = rx_s;
`endif
                    end else begin
                        os_cnt_s = os_cnt_r + OS_ONE;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    os_cnt_s  = OS_ZERO;
                    bit_cnt_s = BC_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Holding register: a simultaneous consume and load keeps valid high.
    always_comb begin
        data_s    = data_r;
        valid_s   = valid_r;
        overrun_s = 1'b0;
        if (frame_good_s) begin
            if (!valid_r || ready_i) begin
                data_s  = shift_r;
                valid_s = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
        end else if (valid_r && ready_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            os_cnt_r     <= OS_ZERO;
            bit_cnt_r    <= BC_ZERO;
            shift_r      <= {DATA_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            os_cnt_r     <= os_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            data_r       <= data_s;
            valid_r      <= valid_s;
            frame_err_r  <= frame_err_s;
            overrun_r    <= overrun_s;
`ifdef UART_RX_PARITY_EN
            par_bit_r    <= par_bit_s;
            parity_err_r <= parity_err_s;
`endif
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx with a tick every
// 4 clocks (64 clocks per bit). Parity cases run when UART_RX_PARITY_EN is set.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_i, en_i, osr_tick_i, rx_i, ready_i;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd_i, parity_err_o;
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int ph       = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int pe_cnt   = 0;
    int fe0, ov0, pe0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
        int         exp_ov;
        bit         clear;
    } vec_t;

    vec_t vecs[5];

    uart_rx #(.OSR(16), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .osr_tick_i   (osr_tick_i),
        .rx_i         (rx_i),
`ifdef UART_RX_PARITY_EN
        .parity_odd_i (parity_odd_i),
        .parity_err_o (parity_err_o),
`endif
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    // One clock: count output pulses at the falling edge, then drive the tick.
    task automatic step();
        @(negedge clk);
        fe_cnt += int'(frame_err_o);
        ov_cnt += int'(overrun_o);
`ifdef UART_RX_PARITY_EN
        pe_cnt += int'(parity_err_o);
`endif
        osr_tick_i = (ph == 0);
        ph = (ph + 1) % 4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one frame tick-aligned; ready_i pulses at ready_step, en_i drops at en_step.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                              input int ready_step, input int en_step);
        logic [10:0] bits;
        int nb;
        bits = PAR ? {stop_bit, par_bit, d, 1'b0} : {1'b1, stop_bit, d, 1'b0};
        nb   = PAR ? 11 : 10;
        while (ph != 0) step();
        for (int i = 0; i < nb * 64; i++) begin
            step();
            rx_i    = bits[i / 64];
            ready_i = (i == ready_step);
            if (i == en_step) en_i = 1'b0;
        end
    endtask

    task automatic pulse_ready(input logic [7:0] exp_data);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("valid_after_ready", {31'd0, valid_o}, 32'd0);
        check("data_held_after_ready", {24'd0, data_o}, {24'd0, exp_data});
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 0, 0, 1'b1};
        vecs[1] = '{8'hFF, 1'b0, 8'hA5, 1'b0, 1, 0, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 8'h81, 1'b1, 0, 0, 1'b1};
        vecs[3] = '{8'h11, 1'b1, 8'h11, 1'b1, 0, 0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 8'h11, 1'b1, 0, 1, 1'b1};

        reset_i = 1'b1; en_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0; osr_tick_i = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd_i = 1'b0;
`endif
        idle(5);
        check("reset_data", {24'd0, data_o}, 32'd0);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err_o}, 32'd0);
        check("reset_overrun", {31'd0, overrun_o}, 32'd0);
        reset_i = 1'b0;
        idle(20);

        // Table: good frame, framing error, recovery, back-to-back overrun.
        for (int v = 0; v < 5; v++) begin
            fe0 = fe_cnt; ov0 = ov_cnt;
            send_frame(vecs[v].d, ^vecs[v].d, vecs[v].stop, -1, -1);
            check("tbl_data", {24'd0, data_o}, {24'd0, vecs[v].exp_data});
            check("tbl_valid", {31'd0, valid_o}, {31'd0, vecs[v].exp_valid});
            check("tbl_frame_err_pulses", fe_cnt - fe0, vecs[v].exp_fe);
            check("tbl_overrun_pulses", ov_cnt - ov0, vecs[v].exp_ov);
            if (vecs[v].clear) pulse_ready(vecs[v].exp_data);
        end

        // Start glitch of 3 ticks: false start, then a normal frame.
        fe0 = fe_cnt;
        while (ph != 0) step();
        rx_i = 1'b0;
        idle(12);
        rx_i = 1'b1;
        idle(64);
        check("glitch_valid", {31'd0, valid_o}, 32'd0);
        check("glitch_frame_err", fe_cnt - fe0, 0);
        send_frame(8'h3C, ^8'h3C, 1'b1, -1, -1);
        check("after_glitch_data", {24'd0, data_o}, 32'h3C);
        check("after_glitch_valid", {31'd0, valid_o}, 32'd1);
        pulse_ready(8'h3C);

        // ready_i high in the completion cycle: replace without overrun.
        ov0 = ov_cnt;
        send_frame(8'h11, ^8'h11, 1'b1, -1, -1);
        send_frame(8'h22, ^8'h22, 1'b1, PAR ? 676 : 612, -1);
        check("same_cycle_data", {24'd0, data_o}, 32'h22);
        check("same_cycle_valid", {31'd0, valid_o}, 32'd1);
        check("same_cycle_overrun", ov_cnt - ov0, 0);
        pulse_ready(8'h22);

        // Enable dropped mid data bit 3 aborts the frame.
        fe0 = fe_cnt;
        send_frame(8'h5A, ^8'h5A, 1'b1, -1, 4 * 64 + 32);
        check("en_drop_valid", {31'd0, valid_o}, 32'd0);
        check("en_drop_frame_err", fe_cnt - fe0, 0);
        en_i = 1'b1;
        idle(8);
        send_frame(8'h5A, ^8'h5A, 1'b1, -1, -1);
        check("reenable_data", {24'd0, data_o}, 32'h5A);
        check("reenable_valid", {31'd0, valid_o}, 32'd1);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        while (ph != 0) step();
        rx_i = 1'b0;
        idle(100);
        reset_i = 1'b1;
        #1;
        check("async_reset_data", {24'd0, data_o}, 32'd0);
        check("async_reset_valid", {31'd0, valid_o}, 32'd0);
        idle(4);
        rx_i = 1'b1;
        idle(4);
        reset_i = 1'b0;
        idle(64);
        send_frame(8'hC3, ^8'hC3, 1'b1, -1, -1);
        check("post_reset_data", {24'd0, data_o}, 32'hC3);
        check("post_reset_valid", {31'd0, valid_o}, 32'd1);
        pulse_ready(8'hC3);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x07: parity bit 0 is wrong, 1 is right.
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h07, 1'b0, 1'b1, -1, -1);
        check("parity_err_pulses", pe_cnt - pe0, 1);
        check("parity_err_valid", {31'd0, valid_o}, 32'd0);
        check("parity_err_no_frame_err", fe_cnt - fe0, 0);
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        check("parity_ok_pulses", pe_cnt - pe0, 0);
        check("parity_ok_data", {24'd0, data_o}, 32'h07);
        check("parity_ok_valid", {31'd0, valid_o}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the uart_ip core. It consumes the oversampled tick from baud_gen (osr_tick_o → osr_tick_i) and deserialises 8N1 frames from the rx line, sampling each bit at its midpoint. Received bytes go into a one-entry holding register with a valid/ready handshake. Framing errors and overruns are flagged. It sits beside baud_gen and the tx path under the UART top.

Parameters:
OSR, 16, oversample ticks per bit; must be even and ≥ 4
DATA_W, 8, data bits per frame, LSB first
SYNC_STAGES, 2, rx_i synchroniser depth (≥ 2)

Ports:
clk_i  in  1  core clock
reset_i  in  1  asynchronous, active-high reset
en_i  in  1  receiver enable
osr_tick_i  in  1  one-cycle oversample tick from baud_gen
rx_i  in  1  asynchronous serial input; idles high
data_o  out  DATA_W  received byte (holding register)
valid_o  out  1  holding register holds unread data
ready_i  in  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
overrun_o  out  1  one-cycle pulse: good frame dropped because holding register full

Behaviour:
- Reset (async): state IDLE, os_cnt=0, bit_cnt=0, shift=0, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, synchroniser flops=1.
- rx_i passes through SYNC_STAGES flops → rx_s. The FSM uses only rx_s.
- FSM and counters advance only on cycles with en_i && osr_tick_i.
- IDLE: tick with rx_s=0 → START, os_cnt←0.
- START: each tick os_cnt++. At os_cnt==OSR/2-1, sample rx_s:
  - rx_s=1: false start → IDLE.
  - rx_s=0: → DATA, os_cnt←0, bit_cnt←0.
- DATA: each tick os_cnt++. At os_cnt==OSR-1: shift←{rx_s, shift[DATA_W-1:1]}, os_cnt←0, bit_cnt++. After bit DATA_W-1 → STOP (or PARITY, see Optional Feature).
- STOP: at os_cnt==OSR-1, sample rx_s, then → IDLE (mid stop bit, so back-to-back frames are accepted).
  - rx_s=1: frame good.
  - rx_s=0: frame_err_o pulses; frame discarded.
- Timing: the stop bit is sampled on the tick OSR/2 + OSR·(DATA_W+1) after the start-detect tick (152 for defaults). Its result appears on the outputs the next clock.
- Good frame, valid_o=0: data_o←shift, valid_o←1.
- Good frame, valid_o=1, ready_i=0: data_o held, new frame dropped, overrun_o pulses.
- Good frame with valid_o=1 && ready_i=1 in the same cycle: old byte consumed, new byte loaded, valid_o stays 1, no overrun.
- Handshake: valid_o && ready_i with no new frame → valid_o←0 next cycle. data_o holds its value after consumption.
- en_i low: FSM → IDLE and counters clear next clock. Holding register, valid_o and handshake still operate.
- en_i high with no tick: state frozen.
- os_cnt width is $clog2(OSR); bit_cnt width is $clog2(DATA_W+1). No wrap occurs outside the compare points.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds input parity_odd_i (0=even, 1=odd) and output parity_err_o (one-cycle pulse, reset 0).
  - PARITY state sits between DATA and STOP and samples at os_cnt==OSR-1.
  - Mismatch: parity_err_o pulses at the stop-bit sample, frame discarded, no overrun or valid update.
  - Framing takes precedence: a frame with both errors pulses both flags.
- Undefined: no ports, no state. Frame is 8N1.

Decomposition:
- uart_pkg: rx_state_t enum (IDLE, START, DATA, PARITY, STOP) and shared OSR default, also used by baud_gen/uart_tx.
- Sub-module uart_sync: parameterised N-flop synchroniser with reset value 1, reusable for other async inputs.

Test Plan:
1. baud_gen div=4 (tick every 4 clocks) driving osr_tick_i; rx frame 0xA5, 16 ticks per bit; ready_i=0 → valid_o=1, data_o=0xA5, no error pulses. Pulse ready_i → valid_o=0 next clock.
2. rx low for 3 ticks then high (glitch) → no valid_o, FSM back in IDLE. A following 0x3C frame is received correctly.
3. Frame 0xFF with stop bit 0 → frame_err_o exactly one pulse, valid_o stays 0. Next frame 0x81 is received.
4. Back-to-back 0x11 then 0x22, ready_i=0 → data_o=0x11, overrun_o one pulse at 0x22 completion. ready_i then clears valid_o. Repeat with ready_i=1 in the completion cycle → data_o=0x22, no overrun.
5. en_i dropped mid data bit 3 of 0x5A → no valid_o. Re-enable, resend 0x5A → valid_o, data_o=0x5A. Also assert reset_i mid-frame → all outputs 0 immediately (async), next frame received.
6. With UART_RX_PARITY_EN: parity_odd_i=0, frame 0x07 with parity bit 0 → parity_err_o one pulse, no valid. Same frame with parity bit 1 → data_o=0x07.
